// File: rtl/port_bind_table.sv
// Port-binding table: bind/release/query 16-bit ports against ENTRIES slots.
// Latency: accept in cycle T -> rsp_valid in T+ENTRIES+2 (full linear scan, no early exit).
// Backpressure: one request in flight; req_ready low until the response handshakes.
//
// Ports:
//   clk, rst_n              clock, async active-low reset
//   req_valid/req_ready     request handshake; req_op (00 bind, 01 release, 10 query, 11 rsvd), req_port
//   rsp_valid/rsp_ready     response handshake; rsp_status (00 OK, 01 TAKEN, 10 FULL, 11 INVALID), rsp_index
//   bound_count             number of occupied slots
module port_bind_table #(
  parameter int ENTRIES = 8,
  parameter int PORT_W  = 16,
  parameter int IDX_W   = $clog2(ENTRIES),
  parameter int CNT_W   = $clog2(ENTRIES + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [1:0]        req_op,
  input  logic [PORT_W-1:0] req_port,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [1:0]        rsp_status,
  output logic [IDX_W-1:0]  rsp_index,
  output logic [CNT_W-1:0]  bound_count
);

  localparam logic [1:0] OP_BIND = 2'b00;
  localparam logic [1:0] OP_REL  = 2'b01;
  localparam logic [1:0] OP_QRY  = 2'b10;

  localparam logic [1:0] ST_OK      = 2'b00;
  localparam logic [1:0] ST_TAKEN   = 2'b01;
  localparam logic [1:0] ST_FULL    = 2'b10;
  localparam logic [1:0] ST_INVALID = 2'b11;

  typedef enum logic [1:0] {S_IDLE, S_SCAN, S_COMMIT, S_RESP} state_t;

  state_t              r_state;
  state_t              w_state_nxt;

  logic [ENTRIES-1:0]  r_vld;
  logic [PORT_W-1:0]   r_port [ENTRIES];
  logic [CNT_W-1:0]    r_count;

  logic [1:0]          r_req_op;
  logic [PORT_W-1:0]   r_req_port;
  logic [IDX_W-1:0]    r_idx;
  logic                r_hit;
  logic [IDX_W-1:0]    r_hit_idx;
  logic                r_free_found;
  logic [IDX_W-1:0]    r_free_idx;

  logic [1:0]          r_status;
  logic [IDX_W-1:0]    r_index;

  logic                w_slot_hit;
  logic                w_scan_last;
  logic [1:0]          w_cm_status;
  logic [IDX_W-1:0]    w_cm_idx;
  logic                w_cm_set;
  logic                w_cm_clr;

  assign req_ready   = (r_state == S_IDLE);
  assign rsp_valid   = (r_state == S_RESP);
  assign rsp_status  = r_status;
  assign rsp_index   = r_index;
  assign bound_count = r_count;

  assign w_slot_hit  = r_vld[r_idx] && (r_port[r_idx] == r_req_port);
  assign w_scan_last = (r_idx == IDX_W'(ENTRIES - 1));

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:   if (req_valid) w_state_nxt = S_SCAN;
      S_SCAN:   if (w_scan_last) w_state_nxt = S_COMMIT;
      S_COMMIT: w_state_nxt = S_RESP;
      S_RESP:   if (rsp_ready) w_state_nxt = S_IDLE;
      default:  w_state_nxt = S_IDLE;
    endcase
  end

  // Commit decision from the completed scan; port 0 and the reserved op are
  // rejected before any table lookup result is considered.
  always_comb begin
    w_cm_status = ST_INVALID;
    w_cm_idx    = '0;
    w_cm_set    = 1'b0;
    w_cm_clr    = 1'b0;
    if (r_req_port != '0) begin
      case (r_req_op)
        OP_BIND: begin
          if (r_hit) begin
            w_cm_status = ST_TAKEN;
            w_cm_idx    = r_hit_idx;
          end else if (!r_free_found) begin
            w_cm_status = ST_FULL;
          end else begin
            w_cm_status = ST_OK;
            w_cm_idx    = r_free_idx;
            w_cm_set    = 1'b1;
          end
        end
        OP_REL: begin
          if (r_hit) begin
            w_cm_status = ST_OK;
            w_cm_idx    = r_hit_idx;
            w_cm_clr    = 1'b1;
          end
        end
        OP_QRY: begin
          if (r_hit) begin
            w_cm_status = ST_OK;
            w_cm_idx    = r_hit_idx;
          end
        end
        default: begin
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_vld        <= '0;
      r_count      <= '0;
      r_req_op     <= '0;
      r_req_port   <= '0;
      r_idx        <= '0;
      r_hit        <= 1'b0;
      r_hit_idx    <= '0;
      r_free_found <= 1'b0;
      r_free_idx   <= '0;
      r_status     <= '0;
      r_index      <= '0;
    end else begin
      r_state <= w_state_nxt;
      case (r_state)
        S_IDLE: begin
          if (req_valid) begin
            r_req_op     <= req_op;
            r_req_port   <= req_port;
            r_idx        <= '0;
            r_hit        <= 1'b0;
            r_free_found <= 1'b0;
          end
        end
        S_SCAN: begin
          if (w_slot_hit) begin
            r_hit     <= 1'b1;
            r_hit_idx <= r_idx;
          end else if (!r_vld[r_idx] && !r_free_found) begin
            // First invalid slot seen is the lowest free one.
            r_free_found <= 1'b1;
            r_free_idx   <= r_idx;
          end
          r_idx <= r_idx + IDX_W'(1);
        end
        S_COMMIT: begin
          r_status <= w_cm_status;
          r_index  <= w_cm_idx;
          if (w_cm_set) begin
            r_vld[r_free_idx] <= 1'b1;
            r_count           <= r_count + CNT_W'(1);
          end
          if (w_cm_clr) begin
            r_vld[r_hit_idx] <= 1'b0;
            r_count          <= r_count - CNT_W'(1);
          end
        end
        default: begin
        end
      endcase
    end
  end

  // Port storage carries no reset: a slot's contents only matter while its
  // valid bit is set.
  always_ff @(posedge clk) begin
    if (r_state == S_COMMIT && w_cm_set) begin
      r_port[r_free_idx] <= r_req_port;
    end
  end

endmodule

// File: tb/tb_port_bind_table.sv
module tb_port_bind_table;

  localparam int ENTRIES = 8;
  localparam int PORT_W  = 16;
  localparam int IDX_W   = 3;
  localparam int CNT_W   = 4;

  localparam logic [1:0] OK = 2'b00, TAKEN = 2'b01, FULL = 2'b10, INV = 2'b11;
  localparam logic [1:0] BIND = 2'b00, REL = 2'b01, QRY = 2'b10, RSV = 2'b11;

  logic              clk;
  logic              rst_n;
  logic              req_valid;
  logic              req_ready;
  logic [1:0]        req_op;
  logic [PORT_W-1:0] req_port;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [1:0]        rsp_status;
  logic [IDX_W-1:0]  rsp_index;
  logic [CNT_W-1:0]  bound_count;

  port_bind_table #(.ENTRIES(ENTRIES), .PORT_W(PORT_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_op(req_op), .req_port(req_port),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_status(rsp_status), .rsp_index(rsp_index),
    .bound_count(bound_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]       st;
    logic [IDX_W-1:0] idx;
    logic [CNT_W-1:0] cnt;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_err = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Starts and ends just after a rising edge with the DUT idle.
  task automatic do_req(input string tag, input logic [1:0] op, input logic [PORT_W-1:0] port,
                        input logic [1:0] st, input logic [IDX_W-1:0] idx,
                        input logic [CNT_W-1:0] cnt, input int hold);
    exp_t e;
    exp_t got;
    int   lat;
    e.st = st; e.idx = idx; e.cnt = cnt;
    sb.push_back(e);
    check({tag, ".req_ready_idle"}, 32'(req_ready), 32'd1);
    req_op = op; req_port = port; req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    lat = 1;
    check({tag, ".req_ready_busy"}, 32'(req_ready), 32'd0);
    while (!rsp_valid && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    check({tag, ".latency"}, 32'(lat), 32'(ENTRIES + 2));
    got = sb.pop_front();
    check({tag, ".status"}, 32'(rsp_status), 32'(got.st));
    check({tag, ".index"},  32'(rsp_index),  32'(got.idx));
    check({tag, ".count"},  32'(bound_count), 32'(got.cnt));
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      check({tag, ".hold_valid"},  32'(rsp_valid),  32'd1);
      check({tag, ".hold_status"}, 32'(rsp_status), 32'(got.st));
      check({tag, ".hold_index"},  32'(rsp_index),  32'(got.idx));
      check({tag, ".hold_ready"},  32'(req_ready),  32'd0);
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    check({tag, ".post_rsp_valid"}, 32'(rsp_valid), 32'd0);
    check({tag, ".post_req_ready"}, 32'(req_ready), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; req_valid = 1'b0; req_op = '0; req_port = '0; rsp_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst.rsp_valid",  32'(rsp_valid),  32'd0);
    check("rst.rsp_status", 32'(rsp_status), 32'd0);
    check("rst.rsp_index",  32'(rsp_index),  32'd0);
    check("rst.count",      32'(bound_count), 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("rst.req_ready", 32'(req_ready), 32'd1);

    do_req("bind22202", BIND, 16'd22202, OK, 3'd0, 4'd1, 0);
    do_req("bind80",    BIND, 16'd80,    OK, 3'd1, 4'd2, 0);
    do_req("bind80dup", BIND, 16'd80,    TAKEN, 3'd1, 4'd2, 0);
    for (int i = 0; i < 6; i++)
      do_req("fill", BIND, 16'(1001 + i), OK, 3'(2 + i), 4'(3 + i), 0);
    do_req("bind443full", BIND, 16'd443,  FULL, 3'd0, 4'd8, 0);
    do_req("rel_slot3",   REL,  16'd1002, OK,   3'd3, 4'd7, 0);
    do_req("rebind443",   BIND, 16'd443,  OK,   3'd3, 4'd8, 0);

    do_req("rel9999",  REL,  16'd9999, INV, 3'd0, 4'd8, 0);
    do_req("bind0",    BIND, 16'd0,    INV, 3'd0, 4'd8, 0);
    do_req("op11",     RSV,  16'd80,   INV, 3'd0, 4'd8, 0);
    do_req("query0",   QRY,  16'd0,    INV, 3'd0, 4'd8, 0);
    do_req("qry80",    QRY,  16'd80,   OK,  3'd1, 4'd8, 0);
    do_req("qry443",   QRY,  16'd443,  OK,  3'd3, 4'd8, 0);
    do_req("qry1006",  QRY,  16'd1006, OK,  3'd7, 4'd8, 0);

    do_req("rel80hold", REL, 16'd80, OK,  3'd1, 4'd7, 5);
    do_req("qry80gone", QRY, 16'd80, INV, 3'd0, 4'd7, 0);
    do_req("bind80lo",  BIND, 16'd80, OK, 3'd1, 4'd8, 0);

    // Reset in the 4th scan cycle of a bind: nothing may be written.
    req_op = BIND; req_port = 16'd5555; req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("midrst.rsp_valid",  32'(rsp_valid),  32'd0);
    check("midrst.rsp_status", 32'(rsp_status), 32'd0);
    check("midrst.rsp_index",  32'(rsp_index),  32'd0);
    check("midrst.count",      32'(bound_count), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("midrst.req_ready", 32'(req_ready), 32'd1);
    check("midrst.count2",    32'(bound_count), 32'd0);

    do_req("qry5555",  QRY,  16'd5555,  INV, 3'd0, 4'd0, 0);
    do_req("qry22202", QRY,  16'd22202, INV, 3'd0, 4'd0, 0);
    do_req("bind7",    BIND, 16'd7,     OK,  3'd0, 4'd1, 0);

    check("sb_empty", 32'(sb.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
